// File: rtl/medidor_pulsos.sv
// rtl/medidor_pulsos.sv - gated pulse-rate meter: counts Pulso edges over a fixed
// window of Clk cycles and publishes the latched count once per window.
module medidor_pulsos #(
  parameter int VENTANA       = 50000,
  parameter int WIDTH         = 8,
  parameter int AMBOS_FLANCOS = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Pulso,
  output logic [WIDTH-1:0] Cuenta,
  output logic             Desborde,
  output logic             Valido
);

  localparam int TW = $clog2(VENTANA);
  localparam logic [TW-1:0]    T_LAST  = TW'(VENTANA - 1);
  localparam logic [WIDTH-1:0] ACC_MAX = '1;

  typedef enum logic {ESPERA, MEDIR} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [1:0]       arm;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] acc;
  logic             sat;

  logic             armed;
  logic             rise, fall;
  logic             pulse_edge;
  logic             acc_full;
  logic [WIDTH-1:0] acc_next;
  logic             sat_next;

  // A static high Pulso at reset release looks like a rising edge; arm masks it.
  assign armed      = (arm == 2'd3);
  assign rise       = s2 & ~s3;
  assign fall       = ~s2 & s3;
  assign pulse_edge = armed & ((AMBOS_FLANCOS != 0) ? (rise | fall) : rise);

  assign acc_full = (acc == ACC_MAX);
  assign acc_next = (pulse_edge && !acc_full) ? acc + WIDTH'(1) : acc;
  assign sat_next = sat | (pulse_edge & acc_full);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ESPERA;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      arm      <= 2'd0;
      timer    <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      Cuenta   <= '0;
      Desborde <= 1'b0;
      Valido   <= 1'b0;
    end else begin
      s1     <= Pulso;
      s2     <= s1;
      s3     <= s2;
      Valido <= 1'b0;
      if (!armed) begin
        arm <= arm + 2'd1;
      end

      case (state)
        ESPERA: begin
          timer <= '0;
          acc   <= '0;
          sat   <= 1'b0;
          if (En) begin
            state <= MEDIR;
          end
        end

        MEDIR: begin
          if (!En) begin
            state <= ESPERA;
            timer <= '0;
            acc   <= '0;
            sat   <= 1'b0;
          end else if (timer == T_LAST) begin
            // The closing cycle's edge belongs to the window being published.
            Cuenta   <= acc_next;
            Desborde <= sat_next;
            Valido   <= 1'b1;
            timer    <= '0;
            acc      <= '0;
            sat      <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
            acc   <= acc_next;
            sat   <= sat_next;
          end
        end

        default: begin
          state <= ESPERA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_pulsos.sv
// tb/tb_medidor_pulsos.sv - self-checking bench for medidor_pulsos with three
// parameterisations and a window-level reference model.
module tb_medidor_pulsos;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       en_ab = 1'b1;
  logic       en_c = 1'b1;
  logic       pulso_ab = 1'b1;
  logic       pulso_c = 1'b1;
  logic [7:0] cuenta_a, cuenta_b;
  logic [2:0] cuenta_c;
  logic       desborde_a, desborde_b, desborde_c;
  logic       valido_a, valido_b, valido_c;

  always #5 Clk = ~Clk;

  medidor_pulsos #(.VENTANA(16), .WIDTH(8), .AMBOS_FLANCOS(0)) u_a (
    .Clk(Clk), .Reset(Reset), .En(en_ab), .Pulso(pulso_ab),
    .Cuenta(cuenta_a), .Desborde(desborde_a), .Valido(valido_a));

  medidor_pulsos #(.VENTANA(16), .WIDTH(8), .AMBOS_FLANCOS(1)) u_b (
    .Clk(Clk), .Reset(Reset), .En(en_ab), .Pulso(pulso_ab),
    .Cuenta(cuenta_b), .Desborde(desborde_b), .Valido(valido_b));

  medidor_pulsos #(.VENTANA(32), .WIDTH(3), .AMBOS_FLANCOS(0)) u_c (
    .Clk(Clk), .Reset(Reset), .En(en_c), .Pulso(pulso_c),
    .Cuenta(cuenta_c), .Desborde(desborde_c), .Valido(valido_c));

  localparam int HLEN = 4096;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int kab      = 0;

  // Input history indexed by the clock edge that samples it.
  bit p_ab [HLEN];
  bit p_c  [HLEN];
  bit e_ab [HLEN];
  bit e_c  [HLEN];
  bit r_h  [HLEN];

  int vent [3] = '{16, 16, 32};
  int cmax [3] = '{255, 255, 7};
  int both [3] = '{0, 1, 0};

  int in_win [3];
  int start  [3];
  int rel    [3];
  int exp_c  [3];
  int exp_d  [3];
  int exp_v  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A transition first seen by the synchroniser at edge k is counted at edge k+2;
  // nothing is counted in the first three edges after reset release.
  function automatic int count_edges(input int i, input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) begin
      bit x, y;
      x = (i == 2) ? p_c[c-2] : p_ab[c-2];
      y = (i == 2) ? p_c[c-3] : p_ab[c-3];
      if (c >= rel[i] + 4) begin
        if (x && !y) n++;
        else if (both[i] != 0 && !x && y) n++;
      end
    end
    return n;
  endfunction

  task automatic model_step(input int i, input int c);
    bit en;
    int n;
    en = (i == 2) ? e_c[c] : e_ab[c];
    exp_v[i] = 0;
    if (r_h[c]) begin
      in_win[i] = 0;
      exp_c[i]  = 0;
      exp_d[i]  = 0;
      rel[i]    = c;
    end else if (in_win[i] == 0) begin
      if (en) begin
        in_win[i] = 1;
        start[i]  = c;
      end
    end else if (!en) begin
      in_win[i] = 0;
    end else if (c - start[i] == vent[i]) begin
      n        = count_edges(i, start[i] + 1, c);
      exp_v[i] = 1;
      exp_c[i] = (n > cmax[i]) ? cmax[i] : n;
      exp_d[i] = (n > cmax[i]) ? 1 : 0;
      start[i] = c;
    end
  endtask

  task automatic tick();
    if (cyc + 1 < HLEN) begin
      p_ab[cyc+1] = pulso_ab;
      p_c[cyc+1]  = pulso_c;
      e_ab[cyc+1] = en_ab;
      e_c[cyc+1]  = en_c;
      r_h[cyc+1]  = Reset;
    end
    @(posedge Clk);
    #1;
    cyc++;
    if (cyc >= HLEN) begin
      $display("FAIL history_overflow: observed cycle %0d expected below %0d", cyc, HLEN);
      $fatal(1, "history overflow");
    end
    for (int i = 0; i < 3; i++) model_step(i, cyc);
    check("valido_a",   valido_a,   exp_v[0]);
    check("cuenta_a",   cuenta_a,   exp_c[0]);
    check("desborde_a", desborde_a, exp_d[0]);
    check("valido_b",   valido_b,   exp_v[1]);
    check("cuenta_b",   cuenta_b,   exp_c[1]);
    check("desborde_b", desborde_b, exp_d[1]);
    check("valido_c",   valido_c,   exp_v[2]);
    check("cuenta_c",   cuenta_c,   exp_c[2]);
    check("desborde_c", desborde_c, exp_d[2]);
  endtask

  task automatic ab_cycle();
    pulso_ab = ((kab / 2) % 2) != 0;
    kab++;
    tick();
  endtask

  initial begin
    int nv, nc, cnt, found, rst_left, ph;

    // Reset with Pulso high and En high.
    repeat (4) begin
      tick();
      check("reset_cuenta_a", cuenta_a, 0);
      check("reset_valido_a", valido_a, 0);
    end
    Reset = 1'b0;
    nv = 0;
    repeat (40) begin
      tick();
      if (valido_a) begin
        nv++;
        check("static_high_cuenta_a", cuenta_a, 0);
        check("static_high_cuenta_b", cuenta_b, 0);
      end
    end
    check("static_high_windows", (nv >= 2), 1);

    // Steady rates: A/B period 4, C period 2 (saturates).
    ph  = $urandom_range(0, 3);
    kab = ph;
    nv  = 0;
    nc  = 0;
    for (int k = 0; k < 160; k++) begin
      pulso_c = k[0];
      ab_cycle();
      if (valido_a) begin
        nv++;
        if (nv >= 3) begin
          check("rate_rise_cuenta", cuenta_a, 4);
          check("rate_both_cuenta", cuenta_b, 8);
          check("rate_valido_pair", valido_b, 1);
        end
      end
      if (valido_c) begin
        nc++;
        if (nc >= 3) begin
          check("sat_cuenta", cuenta_c, 7);
          check("sat_desborde", desborde_c, 1);
        end
      end
    end

    // C slows to period 8.
    nc = 0;
    for (int k = 0; k < 160; k++) begin
      pulso_c = ((k / 4) % 2) != 0;
      ab_cycle();
      if (valido_c) begin
        nc++;
        if (nc >= 3) begin
          check("slow_cuenta", cuenta_c, 4);
          check("slow_desborde", desborde_c, 0);
        end
      end
    end

    // Enable abort 8 cycles into a window.
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      ab_cycle();
      if (valido_a) found = 1;
    end
    check("abort_sync_found", found, 1);
    repeat (8) ab_cycle();
    en_ab = 1'b0;
    repeat (6) begin
      ab_cycle();
      check("abort_no_valido", valido_a, 0);
      check("abort_hold_cuenta", cuenta_a, 4);
    end
    en_ab = 1'b1;
    ab_cycle();
    cnt = 0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      ab_cycle();
      cnt++;
      if (valido_a) found = 1;
    end
    check("abort_restart_latency", cnt, 16);
    check("abort_restart_cuenta", cuenta_a, 4);

    // Boundary: one rising edge counted exactly in the closing cycle.
    pulso_ab = 1'b0;
    nv = 0;
    for (int k = 0; k < 60 && nv < 2; k++) begin
      tick();
      if (valido_a) nv++;
    end
    check("boundary_sync", nv, 2);
    check("boundary_prev_cuenta", cuenta_a, 0);
    repeat (13) tick();
    pulso_ab = 1'b1;
    tick();
    tick();
    tick();
    check("boundary_valido", valido_a, 1);
    check("boundary_cuenta", cuenta_a, 1);
    repeat (16) tick();
    check("boundary_next_valido", valido_a, 1);
    check("boundary_next_cuenta", cuenta_a, 0);

    // Random traffic, enable drops and mid-window resets.
    rst_left = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 2) == 0) pulso_ab = ~pulso_ab;
      if ($urandom_range(0, 3) != 0) pulso_c = ~pulso_c;
      if (en_ab && $urandom_range(0, 99) == 0) en_ab = 1'b0;
      else if (!en_ab && $urandom_range(0, 4) == 0) en_ab = 1'b1;
      if (en_c && $urandom_range(0, 99) == 0) en_c = 1'b0;
      else if (!en_c && $urandom_range(0, 4) == 0) en_c = 1'b1;
      if (rst_left == 0 && $urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 3);
      Reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
